// File: rtl/sdr_config_sequencer_if.sv
// PIO-side and datapath-side signals of the SDR configuration sequencer.
// The host/bench drives the cfg_* words through master; the sequencer owns the rest through slave.
interface sdr_config_sequencer_if;
    logic [31:0] cfg_freq;
    logic [31:0] cfg_ctrl;
    logic [31:0] cfg_cmd;
    logic [31:0] nco_phase_inc;
    logic [7:0]  dec_rate;
    logic [3:0]  gain_shift;
    logic        dp_enable;
    logic        dp_flush;
    logic        busy;
    logic        err;
    logic [7:0]  done_tag;
    logic [7:0]  done_count;

    modport master (
        output cfg_freq, cfg_ctrl, cfg_cmd,
        input  nco_phase_inc, dec_rate, gain_shift, dp_enable, dp_flush,
               busy, err, done_tag, done_count
    );

    modport slave (
        input  cfg_freq, cfg_ctrl, cfg_cmd,
        output nco_phase_inc, dec_rate, gain_shift, dp_enable, dp_flush,
               busy, err, done_tag, done_count
    );
endinterface

// File: rtl/sdr_config_sequencer.sv
// Shadows the PIO config words and applies them to the DDC datapath via flush/load/settle.
// Optional macro SDR_CFG_FAST_FREQ_EN: frequency-only commits skip flush and settle.
module sdr_config_sequencer #(
    parameter int FLUSH_CYCLES  = 64,
    parameter int SETTLE_CYCLES = 256,
    parameter int CNT_W         = 16
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset_n,
    sdr_config_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, LATCH, FLUSH, LOAD, SETTLE} state_t;

    state_t             state;
    logic               last_toggle;
    logic               pending;
    logic               fast;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        sh_freq;
    logic [7:0]         sh_dec;
    logic [3:0]         sh_gain;
    logic               sh_en;
    logic [7:0]         sh_tag;

    logic               commit;
    logic [7:0]         in_dec;
    logic [3:0]         in_gain;
    logic               in_en;
    logic               fast_ok;
    logic               unused_bits;

    assign commit      = bus.cfg_cmd[0] ^ last_toggle;
    assign in_dec      = bus.cfg_ctrl[7:0];
    assign in_gain     = bus.cfg_ctrl[11:8];
    assign in_en       = bus.cfg_ctrl[16];
    assign unused_bits = ^{bus.cfg_ctrl[31:17], bus.cfg_ctrl[15:12],
                           bus.cfg_cmd[31:16], bus.cfg_cmd[7:1]};

`ifdef SDR_CFG_FAST_FREQ_EN
    // Only the NCO word changes and the datapath is already running: no flush needed.
    assign fast_ok = bus.dp_enable && in_en &&
                     (in_dec == bus.dec_rate) && (in_gain == bus.gain_shift);
`else
    assign fast_ok = 1'b0;
`endif

    // NOTE: all state here is registered with non-blocking assignments so every
    // read in this block sees the pre-edge value, regardless of statement order.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state             <= IDLE;
            last_toggle       <= 1'b0;
            pending           <= 1'b0;
            fast              <= 1'b0;
            cnt               <= '0;
            sh_freq           <= '0;
            sh_dec            <= '0;
            sh_gain           <= '0;
            sh_en             <= 1'b0;
            sh_tag            <= '0;
            bus.nco_phase_inc <= '0;
            bus.dec_rate      <= '0;
            bus.gain_shift    <= '0;
            bus.dp_enable     <= 1'b0;
            bus.dp_flush      <= 1'b0;
            bus.busy          <= 1'b0;
            bus.err           <= 1'b0;
            bus.done_tag      <= '0;
            bus.done_count    <= '0;
        end else begin
            last_toggle <= bus.cfg_cmd[0];
            if (state != IDLE && commit) pending <= 1'b1;

            case (state)
                IDLE: begin
                    if (commit || pending) begin
                        state    <= LATCH;
                        pending  <= 1'b0;
                        bus.busy <= 1'b1;
                    end
                end

                LATCH: begin
                    sh_freq <= bus.cfg_freq;
                    sh_dec  <= in_dec;
                    sh_gain <= in_gain;
                    sh_en   <= in_en;
                    sh_tag  <= bus.cfg_cmd[15:8];
                    if (in_dec == 8'd0) begin
                        bus.err  <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        bus.err <= 1'b0;
                        fast    <= fast_ok;
                        if (fast_ok) begin
                            state <= LOAD;
                        end else begin
                            bus.dp_enable <= 1'b0;
                            bus.dp_flush  <= 1'b1;
                            cnt           <= CNT_W'(FLUSH_CYCLES - 1);
                            state         <= FLUSH;
                        end
                    end
                end

                FLUSH: begin
                    if (cnt == '0) begin
                        bus.dp_flush <= 1'b0;
                        state        <= LOAD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                LOAD: begin
                    bus.nco_phase_inc <= sh_freq;
                    bus.dec_rate      <= sh_dec;
                    bus.gain_shift    <= sh_gain;
                    if (fast) begin
                        bus.done_tag   <= sh_tag;
                        bus.done_count <= bus.done_count + 8'd1;
                        if (pending || commit) begin
                            state   <= LATCH;
                            pending <= 1'b0;
                        end else begin
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                        end
                    end else begin
                        bus.dp_enable <= sh_en;
                        cnt           <= CNT_W'(SETTLE_CYCLES - 1);
                        state         <= SETTLE;
                    end
                end

                SETTLE: begin
                    if (cnt == '0) begin
                        bus.done_tag   <= sh_tag;
                        bus.done_count <= bus.done_count + 8'd1;
                        // A commit arriving on the exit cycle still triggers the re-run.
                        if (pending || commit) begin
                            state   <= LATCH;
                            pending <= 1'b0;
                        end else begin
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
